// File: rtl/host_word_ctrl.sv
// host_word_ctrl: host-side front end for the hangman game core.
// Turns the received ASCII byte stream into a 5-letter secret word with a
// start pulse during setup, then into paced, de-duplicated guess strobes
// during play.
module host_word_ctrl #(
  parameter int unsigned HOLD_CYC = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        confirm,
  input  logic        game_rdy,
  input  logic        win,
  input  logic        lose,
  output logic [39:0] setWord,
  output logic        toggle_state,
  output logic [7:0]  guess,
  output logic        enable,
  output logic [2:0]  letter_cnt,
  output logic [4:0]  used_cnt,
  output logic        invalid,
  output logic        dup,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_PLAY  = 2'd1,
    S_HOLD  = 2'd2,
    S_END   = 2'd3
  } phase_e;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC);
  localparam logic [7:0] BKSP      = 8'h08;

  phase_e      state_q, state_d;
  logic [39:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  guess_q, guess_d;
  logic [25:0] mask_q, mask_d;
  logic [4:0]  used_q, used_d;
  logic [7:0]  hold_q, hold_d;
  logic        toggle_q, toggle_d;
  logic        enable_q, enable_d;
  logic        invalid_q, invalid_d;
  logic        dup_q, dup_d;

  logic [7:0]  rx_up;
  logic [7:0]  rx_off;
  logic [4:0]  rx_idx;
  logic        rx_is_letter;

  // Fold lowercase onto uppercase; everything else passes through untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end
    return b;
  endfunction

  function automatic logic is_letter(input logic [7:0] u);
    return (u >= 8'h41) && (u <= 8'h5A);
  endfunction

  assign rx_up        = to_upper(rx_data);
  assign rx_is_letter = is_letter(rx_up);
  assign rx_off       = rx_up - 8'h41;
  assign rx_idx       = rx_off[4:0];

  // State and datapath registers; reset clears the whole game context.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_ENTRY;
      word_q    <= '0;
      cnt_q     <= '0;
      guess_q   <= '0;
      mask_q    <= '0;
      used_q    <= '0;
      hold_q    <= '0;
      toggle_q  <= 1'b0;
      enable_q  <= 1'b0;
      invalid_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      guess_q   <= guess_d;
      mask_q    <= mask_d;
      used_q    <= used_d;
      hold_q    <= hold_d;
      toggle_q  <= toggle_d;
      enable_q  <= enable_d;
      invalid_q <= invalid_d;
      dup_q     <= dup_d;
    end
  end

  // Next-state and pulse decode; pulses default low so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    guess_d   = guess_q;
    mask_d    = mask_q;
    used_d    = used_q;
    hold_d    = hold_q;
    toggle_d  = 1'b0;
    enable_d  = 1'b0;
    invalid_d = 1'b0;
    dup_d     = 1'b0;

    case (state_q)
      S_ENTRY: begin
        // confirm wins over a same-cycle byte, which is discarded
        if (confirm) begin
          if (cnt_q == 3'd5) begin
            toggle_d = 1'b1;
            state_d  = S_PLAY;
          end else begin
            invalid_d = 1'b1;
          end
        end else if (rx_valid) begin
          if (rx_is_letter) begin
            if (cnt_q < 3'd5) begin
              word_d = {word_q[31:0], rx_up};
              cnt_d  = cnt_q + 3'd1;
            end else begin
              invalid_d = 1'b1;
            end
          end else if (rx_data == BKSP) begin
            if (cnt_q != 3'd0) begin
              word_d = {8'h00, word_q[39:8]};
              cnt_d  = cnt_q - 3'd1;
            end
          end else begin
            invalid_d = 1'b1;
          end
        end
      end

      S_PLAY: begin
        // game outcome pre-empts any letter arriving in the same cycle
        if (win || lose) begin
          state_d = S_END;
        end else if (rx_valid) begin
          if (!rx_is_letter) begin
            invalid_d = 1'b1;
          end else if (mask_q[rx_idx]) begin
            dup_d = 1'b1;
          end else if (!game_rdy) begin
            invalid_d = 1'b1;
          end else begin
            guess_d  = rx_up;
            enable_d = 1'b1;
            mask_d   = mask_q | (26'd1 << rx_idx);
            used_d   = used_q + 5'd1;
            hold_d   = HOLD_LOAD;
            state_d  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // the enable cycle is the first HOLD cycle, so leave on the count of 1
        if (win || lose) begin
          state_d = S_END;
        end else if (hold_q <= 8'd1) begin
          state_d = S_PLAY;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end

      S_END: begin
        if (confirm) begin
          word_d  = '0;
          cnt_d   = '0;
          guess_d = '0;
          mask_d  = '0;
          used_d  = '0;
          state_d = S_ENTRY;
        end
      end

      default: begin
        state_d = S_ENTRY;
      end
    endcase
  end

  assign setWord      = word_q;
  assign toggle_state = toggle_q;
  assign guess        = guess_q;
  assign enable       = enable_q;
  assign letter_cnt   = cnt_q;
  assign used_cnt     = used_q;
  assign invalid      = invalid_q;
  assign dup          = dup_q;
  assign phase        = state_q;

endmodule

// File: doc/host_word_ctrl.md
# host_word_ctrl

Host-side front end for the wireless hangman game: it converts the incoming ASCII byte stream into the signals the game-logic core consumes. In setup it assembles the 5-letter secret word in a shift register, with backspace and validation, and issues the start pulse on host confirmation. In play it forwards each new, non-duplicate letter as a guess strobe, paced by the core's ready flag. Sits between the UART/radio byte receiver and the game-logic core.

## Interface
- HOLD_CYC, default 8: cycles after an issued guess during which further letters are ignored (valid range 1-255).
- clk  input  1  system clock; all state changes on rising edge.
- nRst  input  1  asynchronous active-low reset.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  single-cycle strobe qualifying rx_data.
- confirm  input  1  host confirm, single-cycle pulse (debounced upstream).
- game_rdy  input  1  core ready for a guess.
- win  input  1  core win indication (green).
- lose  input  1  core loss indication (red).
- setWord  output  40  secret word; first letter in [39:32], fifth in [7:0].
- toggle_state  output  1  one-cycle start pulse to the core.
- guess  output  8  last accepted guess, uppercase ASCII.
- enable  output  1  one-cycle strobe, high the cycle guess updates.
- letter_cnt  output  3  letters currently entered, 0-5.
- used_cnt  output  5  distinct letters guessed this game, 0-26.
- invalid  output  1  one-cycle pulse: byte or confirm rejected.
- dup  output  1  one-cycle pulse: repeated guess rejected.
- phase  output  2  0=ENTRY, 1=PLAY, 2=HOLD, 3=END.

## Operation
- Normalisation: 0x61-0x7A map to uppercase by subtracting 0x20. 0x41-0x5A are letters. 0x08 is backspace. All other bytes are non-letters.
- ENTRY:
  - Letter with letter_cnt<5: setWord <= {setWord[31:0], L}; letter_cnt+1.
  - Letter with letter_cnt==5: dropped, invalid pulse.
  - Backspace with letter_cnt>0: setWord <= {8'h00, setWord[39:8]}; letter_cnt-1.
  - Backspace with letter_cnt==0: ignored, no pulse.
  - Any other byte: invalid pulse.
  - confirm with letter_cnt==5: toggle_state pulse, go to PLAY.
  - confirm with letter_cnt<5: invalid pulse, stay in ENTRY.
  - confirm and rx_valid in the same cycle: confirm is evaluated and the byte is discarded.
- PLAY: a 26-bit used mask indexes the letter as L-0x41.
  - Letter already set in the mask: dup pulse.
  - Letter not in mask with game_rdy==0: invalid pulse, mask unchanged.
  - Letter not in mask with game_rdy==1: guess <= L, enable pulse, mask bit set, used_cnt+1, go to HOLD.
  - Non-letters, including backspace, in PLAY: invalid pulse.
- HOLD: a down-counter loads HOLD_CYC. rx_valid bytes are silently ignored, with no pulses. When the counter reaches 0, go to PLAY.
- win or lose high in PLAY or HOLD: go to END. END ignores rx_valid.
- confirm in END: clear setWord, letter_cnt, guess, the mask and used_cnt, then go to ENTRY.
- setWord is frozen outside ENTRY. guess holds its value between strobes.

## Timing
- Reset (async): phase=ENTRY, setWord=0, guess=0, letter_cnt=0, used_cnt=0, mask=0. toggle_state, enable, invalid and dup are all 0.
- All outputs are registered. Every response appears the cycle after the sampling edge, which is 1-cycle latency.
- toggle_state and enable are exactly one cycle wide. phase reads PLAY in the same cycle toggle_state is high.
- HOLD lasts exactly HOLD_CYC cycles. phase returns to PLAY on cycle HOLD_CYC+1 after the enable cycle, and a letter is accepted from that cycle onward.
- Reset mid-HOLD or mid-pulse aborts immediately. No pulse completes after nRst falls.
- win/lose take priority over a same-cycle rx_valid letter in PLAY: the letter is not issued.

## Test plan
- Type "hello" then confirm -> setWord=0x48454C4C4F, toggle_state high for 1 cycle, phase=1.
- In ENTRY type "AB", backspace, "CDEF", then "G" -> setWord=0x4143444546, letter_cnt=5, one invalid pulse on "G".
- In ENTRY, confirm with letter_cnt=3, then "1" -> two invalid pulses; phase stays 0.
- In PLAY with game_rdy=1, send 'e' -> guess=0x45, enable for 1 cycle, used_cnt=1. Bytes during the following 8 cycles are ignored. A second 'E' after HOLD -> dup pulse, used_cnt stays 1.
- In PLAY with game_rdy=0, send 'x' -> invalid pulse, no enable. With game_rdy=1, 'x' is then accepted.
- During HOLD, assert win -> phase=3. Confirm -> phase=0 with all registers 0. Pulse nRst low mid-HOLD -> all reset values on the next observation.
